// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions.
// Tag layout, sizing and the per-slot entry record.
package reorder_buffer_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int TAG_WIDTH   = 8;
  localparam int IDX_W       = $clog2(ROB_ENTRIES);

  localparam logic [2:0]           TAG_PREFIX = 3'b001;
  localparam logic [TAG_WIDTH-1:0] NO_TAG     = '0;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  dest_reg;
    logic [63:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_entry.sv
// One reorder buffer slot.
// Clear wins over allocate, which wins over completion.
module rob_entry
  import reorder_buffer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        alloc,
  input  logic [4:0]  alloc_reg,
  input  logic        complete,
  input  logic [63:0] complete_value,
  input  logic        clear,
  output rob_entry_t  entry
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry <= '0;
    end else if (clear) begin
      entry.valid <= 1'b0;
      entry.done  <= 1'b0;
    end else if (alloc) begin
      entry.valid    <= 1'b1;
      entry.done     <= 1'b0;
      entry.dest_reg <= alloc_reg;
    end else if (complete && entry.valid) begin
      entry.done  <= 1'b1;
      entry.value <= complete_value;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Dual-dispatch, single-retire reorder buffer.
// Tags are {prefix, slot index}; pointers carry a wrap bit.
module reorder_buffer #(
  parameter int ROB_ENTRIES = 32,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dispatch1_valid,
  input  logic [4:0]                    dispatch1_dest_reg,
  input  logic                          dispatch2_valid,
  input  logic [4:0]                    dispatch2_dest_reg,
  output logic [TAG_WIDTH-1:0]          tag1_out,
  output logic [TAG_WIDTH-1:0]          tag2_out,
  output logic                          stall_out,
  input  logic                          cdb_valid,
  input  logic [TAG_WIDTH-1:0]          cdb_tag,
  input  logic [63:0]                   cdb_value,
  output logic                          retire_valid,
  output logic [4:0]                    retire_reg,
  output logic [TAG_WIDTH-1:0]          retire_tag,
  output logic [63:0]                   retire_value,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(ROB_ENTRIES):0]  count
);

  import reorder_buffer_pkg::*;

  localparam int IW = $clog2(ROB_ENTRIES);
  localparam int CW = IW + 1;

  logic [IW:0]   head_q;
  logic [IW:0]   tail_q;
  logic [CW-1:0] count_q;

  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic [IW-1:0] tail2_idx;
  logic [IW-1:0] cdb_idx;
  logic          cdb_hit;
  logic          do1;
  logic          do2;
  logic [1:0]    alloc_n;

  rob_entry_t ents [ROB_ENTRIES];

  assign head_idx  = head_q[IW-1:0];
  assign tail_idx  = tail_q[IW-1:0];
  assign tail2_idx = tail_idx + 1'b1;
  assign cdb_idx   = cdb_tag[IW-1:0];
  assign cdb_hit   = cdb_valid
                  && (cdb_tag[TAG_WIDTH-1 -: 3] == TAG_PREFIX);

  // Stall looks at pre-retire occupancy only.
  assign stall_out = count_q > CW'(ROB_ENTRIES - 2);
  assign do1       = dispatch1_valid && !stall_out;
  assign do2       = do1 && dispatch2_valid;
  assign alloc_n   = {1'b0, do1} + {1'b0, do2};

  assign tag1_out = TAG_WIDTH'({TAG_PREFIX, tail_idx});
  assign tag2_out = TAG_WIDTH'({TAG_PREFIX, tail2_idx});

  assign empty = count_q == '0;
  assign full  = count_q == CW'(ROB_ENTRIES);
  assign count = count_q;

  assign retire_valid = !empty && ents[head_idx].done;
  assign retire_reg   = ents[head_idx].dest_reg;
  assign retire_tag   = TAG_WIDTH'({TAG_PREFIX, head_idx});
  assign retire_value = ents[head_idx].value;

  for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_ent
    logic hit1;
    logic hit2;
    assign hit1 = do1 && (tail_idx == IW'(i));
    assign hit2 = do2 && (tail2_idx == IW'(i));

    rob_entry u_ent (
      .clock          (clock),
      .reset          (reset),
      .alloc          (hit1 || hit2),
      .alloc_reg      (hit1 ? dispatch1_dest_reg : dispatch2_dest_reg),
      .complete       (cdb_hit && (cdb_idx == IW'(i))),
      .complete_value (cdb_value),
      .clear          (retire_valid && (head_idx == IW'(i))),
      .entry          (ents[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + (IW+1)'(retire_valid);
      tail_q  <= tail_q + (IW+1)'(alloc_n);
      count_q <= count_q + CW'(alloc_n) - CW'(retire_valid);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Directed vector table, corner sequences and a queue-based model.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dispatch1_valid = 1'b0;
  logic [4:0]  dispatch1_dest_reg = '0;
  logic        dispatch2_valid = 1'b0;
  logic [4:0]  dispatch2_dest_reg = '0;
  logic [7:0]  tag1_out;
  logic [7:0]  tag2_out;
  logic        stall_out;
  logic        cdb_valid = 1'b0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_value = '0;
  logic        retire_valid;
  logic [4:0]  retire_reg;
  logic [7:0]  retire_tag;
  logic [63:0] retire_value;
  logic        full;
  logic        empty;
  logic [5:0]  count;

  reorder_buffer dut (
    .clock              (clock),
    .reset              (reset),
    .dispatch1_valid    (dispatch1_valid),
    .dispatch1_dest_reg (dispatch1_dest_reg),
    .dispatch2_valid    (dispatch2_valid),
    .dispatch2_dest_reg (dispatch2_dest_reg),
    .tag1_out           (tag1_out),
    .tag2_out           (tag2_out),
    .stall_out          (stall_out),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .cdb_value          (cdb_value),
    .retire_valid       (retire_valid),
    .retire_reg         (retire_reg),
    .retire_tag         (retire_tag),
    .retire_value       (retire_value),
    .full               (full),
    .empty              (empty),
    .count              (count)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          dest;
    int          idx;
    bit          done;
    logic [63:0] val;
  } ent_t;

  ent_t q[$];
  int   head = 0;
  int   tail = 0;

  function automatic void model_reset();
    q.delete();
    head = 0;
    tail = 0;
  endfunction

  task automatic model_check(input string tagn);
    int  n;
    bit  rv;
    n  = q.size();
    rv = (n > 0) && q[0].done;
    chk({tagn, ".tag1"},  64'(tag1_out),  64'(32 + tail));
    chk({tagn, ".tag2"},  64'(tag2_out),  64'(32 + (tail + 1) % 32));
    chk({tagn, ".stall"}, 64'(stall_out), 64'((32 - n) < 2));
    chk({tagn, ".rv"},    64'(retire_valid), 64'(rv));
    chk({tagn, ".rtag"},  64'(retire_tag), 64'(32 + head));
    chk({tagn, ".count"}, 64'(count), 64'(n));
    chk({tagn, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tagn, ".full"},  64'(full),  64'(n == 32));
    if (rv) begin
      chk({tagn, ".rreg"}, 64'(retire_reg), 64'(q[0].dest));
      chk({tagn, ".rval"}, retire_value, q[0].val);
    end
  endtask

  function automatic void model_step(
    input bit d1v, input logic [4:0] d1r,
    input bit d2v, input logic [4:0] d2r,
    input bit cv, input logic [7:0] ct, input logic [63:0] cval);
    bit ret;
    bit st;
    ret = (q.size() > 0) && q[0].done;
    st  = (32 - q.size()) < 2;
    if (ret) begin
      void'(q.pop_front());
      head = (head + 1) % 32;
    end
    if (cv && ct[7:5] == 3'b001)
      foreach (q[k])
        if (q[k].idx == int'(ct[4:0])) begin
          q[k].done = 1'b1;
          q[k].val  = cval;
        end
    if (!st && d1v) begin
      q.push_back('{int'(d1r), tail, 1'b0, 64'd0});
      tail = (tail + 1) % 32;
      if (d2v) begin
        q.push_back('{int'(d2r), tail, 1'b0, 64'd0});
        tail = (tail + 1) % 32;
      end
    end
  endfunction

  // Drive at negedge, check model, clock once, return at next negedge.
  task automatic step(
    input bit d1v, input logic [4:0] d1r,
    input bit d2v, input logic [4:0] d2r,
    input bit cv, input logic [7:0] ct, input logic [63:0] cval,
    input string nm);
    dispatch1_valid    = d1v;
    dispatch1_dest_reg = d1r;
    dispatch2_valid    = d2v;
    dispatch2_dest_reg = d2r;
    cdb_valid          = cv;
    cdb_tag            = ct;
    cdb_value          = cval;
    #1;
    model_check(nm);
    @(posedge clock);
    model_step(d1v, d1r, d2v, d2r, cv, ct, cval);
    @(negedge clock);
  endtask

  task automatic idle(input string nm);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 64'd0, nm);
  endtask

  task automatic reset_check(input string nm);
    chk({nm, ".tag1"},  64'(tag1_out), 64'h20);
    chk({nm, ".tag2"},  64'(tag2_out), 64'h21);
    chk({nm, ".stall"}, 64'(stall_out), 64'd0);
    chk({nm, ".rv"},    64'(retire_valid), 64'd0);
    chk({nm, ".rreg"},  64'(retire_reg), 64'd0);
    chk({nm, ".rtag"},  64'(retire_tag), 64'h20);
    chk({nm, ".rval"},  retire_value, 64'd0);
    chk({nm, ".empty"}, 64'(empty), 64'd1);
    chk({nm, ".full"},  64'(full), 64'd0);
    chk({nm, ".count"}, 64'(count), 64'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      int k;
      if (q.size() == 0) break;
      k = -1;
      foreach (q[j]) if (k < 0 && !q[j].done) k = j;
      if (k >= 0)
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'(32 + q[k].idx),
             {$urandom, $urandom}, "drain");
      else
        idle("drain");
    end
    chk("drain.empty", 64'(empty), 64'd1);
  endtask

  typedef struct {
    bit          d1v;
    logic [4:0]  d1r;
    bit          d2v;
    logic [4:0]  d2r;
    bit          cv;
    logic [7:0]  ct;
    logic [63:0] cval;
    logic [7:0]  t1;
    logic [7:0]  t2;
    bit          rv;
    logic [7:0]  rtag;
    logic [4:0]  rreg;
    logic [63:0] rval;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] t_save;
    int wraps;

    tbl[0] = '{1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 8'h00, 64'h0,
               8'h20, 8'h21, 1'b0, 8'h20, 5'd0, 64'h0, 6'd0};
    tbl[1] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h21, 64'hCD,
               8'h22, 8'h23, 1'b0, 8'h20, 5'd0, 64'h0, 6'd2};
    tbl[2] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h20, 64'hAB,
               8'h22, 8'h23, 1'b0, 8'h20, 5'd0, 64'h0, 6'd2};
    tbl[3] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 64'h0,
               8'h22, 8'h23, 1'b1, 8'h20, 5'd1, 64'hAB, 6'd2};
    tbl[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 64'h0,
               8'h22, 8'h23, 1'b1, 8'h21, 5'd2, 64'hCD, 6'd1};
    tbl[5] = '{1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 8'h00, 64'h0,
               8'h22, 8'h23, 1'b0, 8'h22, 5'd0, 64'h0, 6'd0};
    tbl[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 64'h0,
               8'h22, 8'h23, 1'b0, 8'h22, 5'd0, 64'h0, 6'd0};

    @(negedge clock);
    @(negedge clock);
    reset_check("rst0");
    reset = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      dispatch1_valid    = tbl[i].d1v;
      dispatch1_dest_reg = tbl[i].d1r;
      dispatch2_valid    = tbl[i].d2v;
      dispatch2_dest_reg = tbl[i].d2r;
      cdb_valid          = tbl[i].cv;
      cdb_tag            = tbl[i].ct;
      cdb_value          = tbl[i].cval;
      #1;
      chk($sformatf("vec%0d.tag1", i), 64'(tag1_out), 64'(tbl[i].t1));
      chk($sformatf("vec%0d.tag2", i), 64'(tag2_out), 64'(tbl[i].t2));
      chk($sformatf("vec%0d.rv", i), 64'(retire_valid), 64'(tbl[i].rv));
      chk($sformatf("vec%0d.rtag", i), 64'(retire_tag), 64'(tbl[i].rtag));
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d.rreg", i), 64'(retire_reg), 64'(tbl[i].rreg));
        chk($sformatf("vec%0d.rval", i), retire_value, tbl[i].rval);
      end
      step(tbl[i].d1v, tbl[i].d1r, tbl[i].d2v, tbl[i].d2r,
           tbl[i].cv, tbl[i].ct, tbl[i].cval, $sformatf("vec%0d", i));
    end

    // Bogus completions must leave the single in-flight entry untouched.
    step(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 8'h00, 64'd0, "bad.alloc");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h00, 64'h11, "bad.00");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'hE5, 64'h22, "bad.e5");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h25, 64'h33, "bad.inv");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'hC2, 64'h44, "bad.pfx");
    chk("bad.rv", 64'(retire_valid), 64'd0);
    chk("bad.count", 64'(count), 64'd1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h22, 64'h55, "good.cdb");
    chk("good.rv", 64'(retire_valid), 64'd1);
    chk("good.rval", retire_value, 64'h55);
    chk("good.rreg", 64'(retire_reg), 64'd9);
    idle("good.ret");

    // Fill to 31 with single dispatches.
    for (int c = 0; c < 40; c++) begin
      if (q.size() >= 31) break;
      step(1'b1, 5'($urandom), 1'b0, 5'd0, 1'b0, 8'h00, 64'd0, "fill");
    end
    chk("fill.stall", 64'(stall_out), 64'd1);
    chk("fill.count", 64'(count), 64'd31);
    step(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 8'h00, 64'd0, "fill.blk");
    chk("fill.hold", 64'(count), 64'd31);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'(32 + q[0].idx), 64'hBEEF,
         "fill.done");
    chk("fill.rv", 64'(retire_valid), 64'd1);
    t_save = tag1_out;
    step(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 8'h00, 64'd0, "fill.ret");
    chk("fill.cnt30", 64'(count), 64'd30);
    chk("fill.noalloc", 64'(tag1_out), 64'(t_save));

    drain();

    // Steady single dispatch/retire stream through the wrap point.
    wraps = 0;
    for (int c = 0; c < 40; c++) begin
      bit was31;
      bit cv;
      logic [7:0] ct;
      was31 = (tail == 31);
      cv = q.size() > 0;
      ct = cv ? 8'(32 + q[q.size() - 1].idx) : 8'h00;
      step(1'b1, 5'($urandom), 1'b0, 5'd0, cv, ct,
           {$urandom, $urandom}, "wrap");
      if (was31) begin
        wraps++;
        chk("wrap.tag", 64'(tag1_out), 64'h20);
      end
    end
    chk("wrap.seen", 64'(wraps > 0), 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int sel;
      logic [7:0] ct;
      sel = $urandom_range(0, 9);
      if (sel < 7 && q.size() > 0)
        ct = 8'(32 + q[$urandom_range(0, q.size() - 1)].idx);
      else if (sel == 7) ct = 8'h00;
      else if (sel == 8) ct = 8'hE5;
      else ct = 8'($urandom);
      step($urandom_range(0, 2) != 0, 5'($urandom),
           $urandom_range(0, 1) != 0, 5'($urandom),
           $urandom_range(0, 3) != 0, ct, {$urandom, $urandom}, "rand");
    end

    // Asynchronous reset with ten entries in flight.
    drain();
    for (int c = 0; c < 5; c++)
      step(1'b1, 5'(c + 1), 1'b1, 5'(c + 10), 1'b0, 8'h00, 64'd0, "pre");
    chk("pre.count", 64'(count), 64'd10);
    #2;
    reset = 1'b0;
    #1;
    reset_check("arst");
    @(negedge clock);
    reset_check("arst2");
    reset = 1'b1;
    model_reset();
    idle("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
